multi_tachometer: RTL and testbench

MULTI_TACHOMETER -- requirements
Module: multi_tachometer

---
 rtl/tach_pkg.sv | 24 ++
 rtl/clk_enable.sv | 30 +++
 rtl/tach_channel.sv | 119 +++++++++++
 rtl/multi_tachometer.sv | 104 ++++++++++
 tb/tb_multi_tachometer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/tach_pkg.sv
// Shared types and constants for the multi-channel tachometer.
// Holds the FSM state type, the edge-counter width and the RPM scale helper.
package tach_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tach_state_t;

    localparam int EDGE_W = 16;
    localparam longint unsigned CLK_HZ = 64'd125_000_000;

    // 16.16 factor mapping one window's edge count to RPM, rounded to nearest.
    function automatic int unsigned rpm_scale(input int tick_div,
                                              input int window_ticks,
                                              input int pulses_per_rev);
        longint unsigned num;
        longint unsigned den;
        num = 64'd60 * CLK_HZ * 64'd65536;
        den = 64'(tick_div) * 64'(window_ticks) * 64'(pulses_per_rev);
        return 32'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/clk_enable.sv
// Free-running divider producing a one-cycle tick every DIV clocks while run is high.
// clear restarts the count so the first tick lands exactly DIV cycles later.
module clk_enable #(
    parameter int DIV = 12500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/tach_channel.sv
// One tachometer channel: input synchronizer, tick-sampled glitch filter,
// per-window edge counter, RPM conversion and stall detection.
module tach_channel
    import tach_pkg::*;
#(
    parameter int          FILTER_LEN    = 2,
    parameter int          RPM_W         = 12,
    parameter int          STALL_WINDOWS = 4,
    parameter int unsigned RPM_SCALE     = 1092267
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse,
    input  logic             clear,
    input  logic             tick,
    input  logic             window_end,
    output logic [RPM_W-1:0] rpm,
    output logic             overflow,
    output logic             stalled
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int SW = $clog2(STALL_WINDOWS + 1);
    localparam logic [FW-1:0] AGREE_LAST = FW'(FILTER_LEN - 1);
    localparam logic [47:0] SCALE   = 48'(RPM_SCALE);
    localparam logic [47:0] RPM_MAX = (48'd1 << RPM_W) - 48'd1;

    logic [1:0]        sync;
    logic              level;
    logic              filt;
    logic [FW-1:0]     agree;
    logic [EDGE_W-1:0] count;
    logic              count_ovf;
    logic [SW-1:0]     zero_windows;
    logic              rise;
    logic [47:0]       product;
    logic [47:0]       scaled;
    logic              rpm_sat;

    assign level   = sync[1];
    assign rise    = tick && level && !filt && (agree == AGREE_LAST);
    assign product = 48'(count) * SCALE;
    assign scaled  = (product + 48'd32768) >> 16;
    assign rpm_sat = scaled > RPM_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], pulse};
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt  <= 1'b0;
            agree <= '0;
        end else if (clear) begin
            filt  <= 1'b0;
            agree <= '0;
        end else if (tick) begin
            if (level != filt) begin
                if (agree == AGREE_LAST) begin
                    filt  <= level;
                    agree <= '0;
                end else begin
                    agree <= agree + FW'(1);
                end
            end else begin
                agree <= '0;
            end
        end
    end

    // An edge landing on the window-end tick opens the next window's count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            count_ovf <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            count_ovf <= 1'b0;
        end else if (window_end) begin
            count     <= EDGE_W'(rise);
            count_ovf <= 1'b0;
        end else if (rise) begin
            if (count == '1) begin
                count_ovf <= 1'b1;
            end else begin
                count <= count + EDGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpm          <= '0;
            overflow     <= 1'b0;
            stalled      <= 1'b0;
            zero_windows <= '0;
        end else if (clear) begin
            zero_windows <= '0;
        end else if (window_end) begin
            rpm      <= rpm_sat ? RPM_MAX[RPM_W-1:0] : scaled[RPM_W-1:0];
            overflow <= count_ovf || rpm_sat;
            if (count == '0) begin
                if (zero_windows != SW'(STALL_WINDOWS)) begin
                    zero_windows <= zero_windows + SW'(1);
                end
                stalled <= (zero_windows >= SW'(STALL_WINDOWS - 1));
            end else begin
                zero_windows <= '0;
                stalled      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_tachometer.sv
// Multi-channel tachometer: shared tick and window timing, IDLE/RUN control,
// and NUM_CH independent channels whose results update together each window.
module multi_tachometer
    import tach_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          TICK_DIV       = 12500,
    parameter int          WINDOW_TICKS   = 100,
    parameter int          PULSES_PER_REV = 360,
    parameter int          FILTER_LEN     = 2,
    parameter int          RPM_W          = 12,
    parameter int          STALL_WINDOWS  = 4,
    parameter int unsigned RPM_SCALE      = rpm_scale(TICK_DIV, WINDOW_TICKS, PULSES_PER_REV)
) (
    input  logic                         clk_in,
    input  logic                         reset_n_in,
    input  logic                         enable_in,
    input  logic [NUM_CH-1:0]            tach_pulse_in,
    output logic [NUM_CH-1:0][RPM_W-1:0] rpm_out,
    output logic                         rpm_valid_out,
    output logic [NUM_CH-1:0]            overflow_out,
    output logic [NUM_CH-1:0]            stalled_out
);

    localparam int WW = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_TICKS - 1);

    logic [1:0]    rst_sync;
    logic          rst_n;
    tach_state_t   state;
    logic          start;
    logic          run;
    logic          tick;
    logic [WW-1:0] win_count;
    logic          window_end;

    // Assertion reaches every flop at once; release is retimed to clk_in.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n      = rst_sync[1];
    assign start      = (state == IDLE) && enable_in;
    assign run        = (state == RUN) && enable_in;
    assign window_end = tick && (win_count == WIN_LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rpm_valid_out <= 1'b0;
        end else begin
            rpm_valid_out <= window_end;
            case (state)
                IDLE:    if (enable_in)  state <= RUN;
                RUN:     if (!enable_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    clk_enable #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk_in),
        .rst_n(rst_n),
        .clear(start),
        .run  (run),
        .tick (tick)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (start) begin
            win_count <= '0;
        end else if (tick) begin
            win_count <= (win_count == WIN_LAST) ? '0 : win_count + WW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tach_channel #(
            .FILTER_LEN   (FILTER_LEN),
            .RPM_W        (RPM_W),
            .STALL_WINDOWS(STALL_WINDOWS),
            .RPM_SCALE    (RPM_SCALE)
        ) u_channel (
            .clk       (clk_in),
            .rst_n     (rst_n),
            .pulse     (tach_pulse_in[i]),
            .clear     (start),
            .tick      (tick),
            .window_end(window_end),
            .rpm       (rpm_out[i]),
            .overflow  (overflow_out[i]),
            .stalled   (stalled_out[i])
        );
    end

endmodule

// File: tb/tb_multi_tachometer.sv
// Bench for multi_tachometer: two instances (12-bit and 8-bit RPM) share one
// tick-aligned pulse stimulus; per-window expectations are queued and checked on each strobe.
module tb_multi_tachometer;

    localparam int TD      = 4;
    localparam int WT      = 128;
    localparam int WIN_CYC = TD * WT;

    typedef struct {
        int e0, e1;
        int r0, r1, q0, q1;
        logic [1:0] ovf, ovf8, stall;
    } vec_t;

    typedef struct {
        int cyc;
        int win;
        int r0, r1, q0, q1;
        logic [1:0] ovf, ovf8, stall;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;
    logic [1:0] tach = '0;

    logic [1:0][11:0] rpm12;
    logic             valid12;
    logic [1:0]       ovf12;
    logic [1:0]       stall12;
    logic [1:0][7:0]  rpm8;
    logic             valid8;
    logic [1:0]       ovf8;
    logic [1:0]       stall8;

    exp_t sb[$];
    vec_t vecs[7];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int run_start = 0;
    int win_idx = 0;
    int win_total = 0;

    multi_tachometer #(
        .NUM_CH(2), .TICK_DIV(TD), .WINDOW_TICKS(WT), .PULSES_PER_REV(360),
        .FILTER_LEN(2), .RPM_W(12), .STALL_WINDOWS(4), .RPM_SCALE(1092267)
    ) dut (
        .clk_in(clk), .reset_n_in(reset_n), .enable_in(enable), .tach_pulse_in(tach),
        .rpm_out(rpm12), .rpm_valid_out(valid12), .overflow_out(ovf12), .stalled_out(stall12)
    );

    multi_tachometer #(
        .NUM_CH(2), .TICK_DIV(TD), .WINDOW_TICKS(WT), .PULSES_PER_REV(360),
        .FILTER_LEN(2), .RPM_W(8), .STALL_WINDOWS(4), .RPM_SCALE(1092267)
    ) dut8 (
        .clk_in(clk), .reset_n_in(reset_n), .enable_in(enable), .tach_pulse_in(tach),
        .rpm_out(rpm8), .rpm_valid_out(valid8), .overflow_out(ovf8), .stalled_out(stall8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [WT-1:0] makeTrain(input int edges);
        logic [WT-1:0] p;
        p = '0;
        for (int k = 1; k <= WT; k++) begin
            p[k-1] = (k <= 4 * edges) && (((k - 1) % 4) < 2);
        end
        return p;
    endfunction

    function automatic exp_t makeExp(input int r0, input int r1, input int q0, input int q1,
                                     input logic [1:0] ovf, input logic [1:0] ovf_8,
                                     input logic [1:0] stall);
        exp_t x;
        x.cyc = 0;
        x.win = 0;
        x.r0 = r0;
        x.r1 = r1;
        x.q0 = q0;
        x.q1 = q1;
        x.ovf = ovf;
        x.ovf8 = ovf_8;
        x.stall = stall;
        return x;
    endfunction

    // Drives one full window, one pattern bit per tick, and queues what its strobe must show.
    task automatic applyStimulus(input logic [WT-1:0] p0, input logic [WT-1:0] p1, input exp_t e);
        exp_t x;
        x = e;
        win_idx++;
        win_total++;
        x.cyc = run_start + WIN_CYC * win_idx;
        x.win = win_total;
        sb.push_back(x);
        for (int c = 0; c < WIN_CYC; c++) begin
            @(negedge clk);
            tach[0] = p0[c / TD];
            tach[1] = p1[c / TD];
        end
    endtask

    task automatic startRun();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        run_start = cyc;
        win_idx = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rpm12"}, 32'(rpm12), 0);
        checkOutput({tag, "_valid"}, 32'({valid12, valid8}), 0);
        checkOutput({tag, "_ovf12"}, 32'(ovf12), 0);
        checkOutput({tag, "_stall12"}, 32'(stall12), 0);
        checkOutput({tag, "_rpm8"}, 32'(rpm8), 0);
        checkOutput({tag, "_flags8"}, 32'({ovf8, stall8}), 0);
    endtask

    always @(negedge clk) begin
        if (valid12 || valid8) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                checkOutput($sformatf("w%0d_strobe_cycle", x.win), cyc, x.cyc);
                checkOutput($sformatf("w%0d_valid_pair", x.win), 32'({valid12, valid8}), 3);
                checkOutput($sformatf("w%0d_rpm0", x.win), 32'(rpm12[0]), x.r0);
                checkOutput($sformatf("w%0d_rpm1", x.win), 32'(rpm12[1]), x.r1);
                checkOutput($sformatf("w%0d_ovf", x.win), 32'(ovf12), 32'(x.ovf));
                checkOutput($sformatf("w%0d_stall", x.win), 32'(stall12), 32'(x.stall));
                checkOutput($sformatf("w%0d_rpm8_0", x.win), 32'(rpm8[0]), x.q0);
                checkOutput($sformatf("w%0d_rpm8_1", x.win), 32'(rpm8[1]), x.q1);
                checkOutput($sformatf("w%0d_ovf8", x.win), 32'(ovf8), 32'(x.ovf8));
                checkOutput($sformatf("w%0d_stall8", x.win), 32'(stall8), 32'(x.stall));
            end
        end
    end

    initial begin
        logic [WT-1:0] p;

        vecs[0] = '{e0: 30, e1: 0,  r0: 500, r1: 0,   q0: 255, q1: 0,   ovf: 2'b00, ovf8: 2'b01, stall: 2'b00};
        vecs[1] = '{e0: 20, e1: 0,  r0: 333, r1: 0,   q0: 255, q1: 0,   ovf: 2'b00, ovf8: 2'b01, stall: 2'b00};
        vecs[2] = '{e0: 10, e1: 0,  r0: 167, r1: 0,   q0: 167, q1: 0,   ovf: 2'b00, ovf8: 2'b00, stall: 2'b00};
        vecs[3] = '{e0: 1,  e1: 0,  r0: 17,  r1: 0,   q0: 17,  q1: 0,   ovf: 2'b00, ovf8: 2'b00, stall: 2'b10};
        vecs[4] = '{e0: 0,  e1: 1,  r0: 0,   r1: 17,  q0: 0,   q1: 17,  ovf: 2'b00, ovf8: 2'b00, stall: 2'b00};
        vecs[5] = '{e0: 2,  e1: 3,  r0: 33,  r1: 50,  q0: 33,  q1: 50,  ovf: 2'b00, ovf8: 2'b00, stall: 2'b00};
        vecs[6] = '{e0: 31, e1: 31, r0: 517, r1: 517, q0: 255, q1: 255, ovf: 2'b00, ovf8: 2'b11, stall: 2'b00};

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        startRun();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(makeTrain(vecs[i].e0), makeTrain(vecs[i].e1),
                          makeExp(vecs[i].r0, vecs[i].r1, vecs[i].q0, vecs[i].q1,
                                  vecs[i].ovf, vecs[i].ovf8, vecs[i].stall));
        end

        // Single-tick glitch must be rejected; a two-tick pulse counts once.
        p = '0;
        p[9] = 1'b1;
        applyStimulus(p, makeTrain(1), makeExp(0, 17, 0, 17, 2'b00, 2'b00, 2'b00));
        p = '0;
        p[19] = 1'b1;
        p[20] = 1'b1;
        applyStimulus(p, '0, makeExp(17, 0, 17, 0, 2'b00, 2'b00, 2'b00));

        // Edge accepted on the window-end tick belongs to the following window.
        p = '0;
        p[WT-2] = 1'b1;
        p[WT-1] = 1'b1;
        applyStimulus(p, makeTrain(1), makeExp(0, 17, 0, 17, 2'b00, 2'b00, 2'b00));
        applyStimulus('0, makeTrain(1), makeExp(17, 17, 17, 17, 2'b00, 2'b00, 2'b00));

        // Drop enable mid-window: outputs hold, no strobe, restart needs a full window.
        tach = '0;
        repeat (100) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                checkOutput($sformatf("idle_valid_%0d", i), 32'({valid12, valid8}), 0);
                checkOutput($sformatf("idle_hold_rpm0_%0d", i), 32'(rpm12[0]), 17);
                checkOutput($sformatf("idle_hold_rpm1_%0d", i), 32'(rpm12[1]), 17);
            end
        end
        startRun();
        applyStimulus(makeTrain(5), '0, makeExp(83, 0, 83, 0, 2'b00, 2'b00, 2'b00));

        // Reset asserted mid-window clears outputs without waiting for a clock.
        repeat (200) @(negedge clk);
        checkOutput("pre_reset_rpm0", 32'(rpm12[0]), 83);
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_valid", 32'({valid12, valid8}), 0);

        startRun();
        applyStimulus(makeTrain(30), '0, makeExp(500, 0, 255, 0, 2'b00, 2'b01, 2'b00));

        repeat (20) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
